rv32i_mem_arbiter: RTL and testbench
====================================

// Module: rv32i_mem_arbiter
// PURPOSE
//  Shares one single-ported instruction/data memory between the fetch stage (instruction port)
//  and the memory stage (data port). Wishbone-style stb/ack on all three sides. Data has
//  priority with a bounded streak so fetch never starves. A watchdog ends any hung transaction.
// PARAMETERS
//  MAX_DATA_STREAK  4    consecutive data grants allowed while inst waits (legal 1..15)
//  TIMEOUT_CYCLES   255  cycles of o_mem_stb without i_mem_ack before error-terminate (1..65535)
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst_n        in   1   reset, synchronous, active-low
//  i_stb_inst     in   1   instruction request (level; held high = back-to-back requests)
//  i_iaddr        in   32  instruction address
//  o_ack_inst     out  1   instruction transaction done (1-cycle pulse)
//  o_inst         out  32  instruction data, valid with o_ack_inst
//  i_stb_data     in   1   data request, held until o_ack_data
//  i_we_data      in   1   1 = store, 0 = load
//  i_daddr        in   32  data address
//  i_wdata        in   32  store data
//  i_wsel         in   4   store byte enables
//  o_ack_data     out  1   data transaction done (1-cycle pulse)
//  o_rdata        out  32  load data, valid with o_ack_data
//  o_err          out  1   with an ack: transaction ended by timeout
//  o_mem_stb      out  1   memory request
//  o_mem_we       out  1   memory write enable
//  o_mem_addr     out  32  memory address
//  o_mem_wdata    out  32  memory write data
//  o_mem_sel      out  4   memory byte enables (4'hF for every read)
//  i_mem_ack      in   1   memory done; may arrive in the cycle o_mem_stb first rises
//  i_mem_rdata    in   32  memory read data, valid with i_mem_ack
// BEHAVIOUR
//  - Reset (i_rst_n low at posedge): state IDLE, streak=0, timer=0; all registered outputs 0.
//    Reset mid-transaction abandons it: o_mem_stb low next cycle, no ack to requester.
//  - FSM IDLE/INST/DATA. IDLE: sample requests; on grant register addr/we/wdata/sel, go to
//    INST or DATA. INST/DATA: o_mem_stb=1 with registered fields, until i_mem_ack or timeout.
//  - Grant in IDLE: data only -> DATA; inst only -> INST; both -> DATA unless
//    streak==MAX_DATA_STREAK, then INST. streak++ on data grant while i_stb_inst high
//    (saturating); streak=0 on inst grant or when IDLE sees i_stb_inst low.
//  - Completion: o_ack_x = i_mem_ack & (state==x), combinational; o_inst/o_rdata =
//    i_mem_rdata pass-through. Next state IDLE. Requests seen in the ack cycle are not
//    sampled; IDLE next cycle arbitrates afresh (no duplicate issue of a held data stb).
//  - Latency: request in IDLE at cycle N -> o_mem_stb at N+1 -> ack earliest N+1.
//    Sustained throughput: one transaction per 2 cycles with zero-wait memory.
//  - Timeout: timer counts cycles in INST/DATA, cleared in IDLE. At timer==TIMEOUT_CYCLES-1
//    without i_mem_ack: o_ack_x=1, o_err=1, o_inst/o_rdata=0, o_mem_stb drops, go IDLE.
//    i_mem_ack in the same cycle wins: normal ack, o_err=0.
//  - No abort: once issued a transaction always completes (ack or timeout), even if the
//    requester dropped stb (fetch PC redirect); the ack is still pulsed and may be ignored.
//  - Stores: o_mem_we=i_we_data, o_mem_sel=i_wsel latched at grant; loads and fetches
//    drive o_mem_we=0, o_mem_sel=4'hF, o_mem_wdata=0.
//  - Request fields must be stable while stb high; changes after grant have no effect.
// STRUCTURE
//  - rv32i_mem_pkg: arb_state_t enum {ARB_IDLE, ARB_INST, ARB_DATA}, SEL_WORD=4'hF,
//    streak/timer width localparams via $clog2.
//  - One sub-module: rv32i_mem_watchdog (load/clear, count, expire pulse), reused later
//    by the peripheral bus bridge.
// TESTING
//  1. Inst only, mem acks 2 cycles after stb, i_iaddr=0x100 -> o_mem_addr=0x100, we=0,
//     sel=F; o_ack_inst 1 cycle with o_inst=i_mem_rdata; no o_err.
//  2. Both stb continuously high, zero-wait mem, MAX_DATA_STREAK=4 -> grant order
//     D,D,D,D,I,D,D,D,D,I; inst never waits more than 4 data transactions.
//  3. Store daddr=0x2004, wdata=0xDEADBEEF, wsel=4'b0011 -> memory sees we=1, sel=0011,
//     exact data; exactly one o_ack_data, no second issue while stb held through ack.
//  4. Mem never acks, TIMEOUT_CYCLES=8 -> o_mem_stb high 8 cycles, then o_ack_data=o_err=1,
//     o_rdata=0; next request is served normally.
//  5. i_rst_n low for 1 cycle mid-INST -> next cycle o_mem_stb=0, no acks, state IDLE;
//     pending inst stb re-granted at next IDLE.
//  6. i_mem_ack in final timeout cycle -> normal ack with data, o_err=0.

Source files
------------

// File: rtl/rv32i_mem_pkg.sv
// Shared types and widths for the RV32I memory arbiter and its watchdog.
package rv32i_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_INST = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic [3:0] SEL_WORD = 4'hF;

    // Sized for the largest legal parameter values so every instance shares one width.
    localparam int STREAK_MAX_LEGAL = 15;
    localparam int STREAK_W         = $clog2(STREAK_MAX_LEGAL + 1);
    localparam int TIMER_MAX_LEGAL  = 65535;
    localparam int TIMER_W          = $clog2(TIMER_MAX_LEGAL + 1);

endpackage

// File: rtl/rv32i_mem_watchdog.sv
// Cycle watchdog: counts while enabled, clears on request, flags the final allowed cycle.
module rv32i_mem_watchdog #(
    parameter int LIMIT = 255,
    parameter int CNT_W = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expire is asserted during the last allowed cycle so the owner can terminate in it.
    assign o_expire = i_en && (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates one memory port between fetch and data; data first, bounded streak, watchdog end.
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stb_inst,
    input  logic [31:0] i_iaddr,
    output logic        o_ack_inst,
    output logic [31:0] o_inst,
    input  logic        i_stb_data,
    input  logic        i_we_data,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wsel,
    output logic        o_ack_data,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_mem_stb,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_sel,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              w_grant_data;
    logic              w_grant_inst;
    logic              w_busy;
    logic              w_expire;
    logic [STREAK_W-1:0] r_streak;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_sel;
    logic              r_we;

    assign w_busy = (r_state != ARB_IDLE);

    rv32i_mem_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (TIMER_W)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (!w_busy),
        .i_en     (w_busy),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_grant_data = 1'b0;
        w_grant_inst = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // Fetch wins a simultaneous request only once the data streak is exhausted.
                if (i_stb_data && !(i_stb_inst && (r_streak == STREAK_W'(MAX_DATA_STREAK)))) begin
                    w_grant_data = 1'b1;
                    w_next       = ARB_DATA;
                end else if (i_stb_inst) begin
                    w_grant_inst = 1'b1;
                    w_next       = ARB_INST;
                end
            end
            ARB_INST, ARB_DATA: begin
                if (i_mem_ack || w_expire) begin
                    w_next = ARB_IDLE;
                end
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        o_mem_stb  = w_busy;
        o_ack_inst = (r_state == ARB_INST) && (i_mem_ack || w_expire);
        o_ack_data = (r_state == ARB_DATA) && (i_mem_ack || w_expire);
        o_err      = w_expire && !i_mem_ack;
        o_inst     = i_mem_ack ? i_mem_rdata : '0;
        o_rdata    = i_mem_ack ? i_mem_rdata : '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_sel    <= '0;
            r_we     <= 1'b0;
            r_streak <= '0;
        end else if (r_state == ARB_IDLE) begin
            if (w_grant_data) begin
                r_addr  <= i_daddr;
                r_we    <= i_we_data;
                r_wdata <= i_we_data ? i_wdata : '0;
                r_sel   <= i_we_data ? i_wsel : SEL_WORD;
            end else if (w_grant_inst) begin
                r_addr  <= i_iaddr;
                r_we    <= 1'b0;
                r_wdata <= '0;
                r_sel   <= SEL_WORD;
            end
            if (w_grant_inst || !i_stb_inst) begin
                r_streak <= '0;
            end else if (w_grant_data && (r_streak != STREAK_W'(MAX_DATA_STREAK))) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_we    = r_we;
    assign o_mem_wdata = r_wdata;
    assign o_mem_sel   = r_sel;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a streak of 4 and an 8-cycle watchdog.
module tb_rv32i_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        stb_inst;
    logic [31:0] iaddr;
    logic        ack_inst;
    logic [31:0] inst;
    logic        stb_data;
    logic        we_data;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    logic        ack_data;
    logic [31:0] rdata;
    logic        err;
    logic        mem_stb;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    rv32i_mem_arbiter #(
        .MAX_DATA_STREAK (4),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_stb_inst  (stb_inst),
        .i_iaddr     (iaddr),
        .o_ack_inst  (ack_inst),
        .o_inst      (inst),
        .i_stb_data  (stb_data),
        .i_we_data   (we_data),
        .i_daddr     (daddr),
        .i_wdata     (wdata),
        .i_wsel      (wsel),
        .o_ack_data  (ack_data),
        .o_rdata     (rdata),
        .o_err       (err),
        .o_mem_stb   (mem_stb),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_sel   (mem_sel),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int grants;
        int cycles;
        logic exp_i;
        clk       = 1'b0;
        rst_n     = 1'b0;
        stb_inst  = 1'b0;
        iaddr     = '0;
        stb_data  = 1'b0;
        we_data   = 1'b0;
        daddr     = '0;
        wdata     = '0;
        wsel      = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        step();
        step();

        // Reset state
        #1;
        chk("rst_mem_stb", mem_stb, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_ack_inst", ack_inst, 0);
        chk("rst_ack_data", ack_data, 0);
        chk("rst_err", err, 0);

        // 1. Fetch only, memory acks two cycles after stb rises
        @(negedge clk);
        rst_n    = 1'b1;
        stb_inst = 1'b1;
        iaddr    = 32'h0000_0100;
        #1;
        chk("t1_idle_stb", mem_stb, 0);
        step();
        stb_inst = 1'b0;
        #1;
        chk("t1_mem_stb", mem_stb, 1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_sel", mem_sel, 4'hF);
        chk("t1_mem_wdata", mem_wdata, 0);
        chk("t1_no_early_ack", ack_inst, 0);
        step();
        #1;
        chk("t1_still_wait", ack_inst, 0);
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0013;
        #1;
        chk("t1_ack_inst", ack_inst, 1);
        chk("t1_inst", inst, 32'h13);
        chk("t1_err", err, 0);
        chk("t1_no_ack_data", ack_data, 0);
        step();
        mem_ack = 1'b0;
        #1;
        chk("t1_back_idle", mem_stb, 0);
        chk("t1_ack_gone", ack_inst, 0);

        // 3. Store with stb held through the ack
        stb_data = 1'b1;
        we_data  = 1'b1;
        daddr    = 32'h0000_2004;
        wdata    = 32'hDEAD_BEEF;
        wsel     = 4'b0011;
        step();
        #1;
        chk("t3_mem_stb", mem_stb, 1);
        chk("t3_mem_we", mem_we, 1);
        chk("t3_mem_sel", mem_sel, 4'b0011);
        chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t3_mem_addr", mem_addr, 32'h2004);
        mem_ack = 1'b1;
        #1;
        chk("t3_ack_data", ack_data, 1);
        chk("t3_err", err, 0);
        step();
        mem_ack = 1'b0;
        #1;
        chk("t3_no_reissue", mem_stb, 0);
        chk("t3_single_ack", ack_data, 0);
        stb_data = 1'b0;
        we_data  = 1'b0;
        step();
        #1;
        chk("t3_stay_idle", mem_stb, 0);

        // 2. Both requesters held high, zero-wait memory
        stb_inst  = 1'b1;
        stb_data  = 1'b1;
        iaddr     = 32'h0000_0400;
        daddr     = 32'h0000_3000;
        mem_rdata = 32'h1111_2222;
        grants    = 0;
        cycles    = 0;
        while (grants < 10 && cycles < 40) begin
            mem_ack = mem_stb;
            #1;
            if (ack_data || ack_inst) begin
                exp_i = (grants == 4) || (grants == 9);
                chk("t2_grant_inst", ack_inst, exp_i);
                chk("t2_grant_data", ack_data, !exp_i);
                chk("t2_grant_addr", mem_addr, exp_i ? 32'h400 : 32'h3000);
                chk("t2_grant_sel", mem_sel, 4'hF);
                grants++;
            end
            cycles++;
            if (grants == 10) begin
                stb_inst = 1'b0;
                stb_data = 1'b0;
            end
            step();
        end
        mem_ack = 1'b0;
        chk("t2_grant_count", grants, 10);
        chk("t2_cycles", cycles, 20);
        #1;
        chk("t2_idle_after", mem_stb, 0);

        // 4. Memory never acks a load; watchdog ends it after 8 cycles
        stb_data  = 1'b1;
        daddr     = 32'h0000_5000;
        mem_rdata = 32'hFFFF_0000;
        step();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t4_stb_held", mem_stb, 1);
            if (i < 7) begin
                chk("t4_no_ack", ack_data, 0);
                chk("t4_no_err", err, 0);
                step();
            end else begin
                chk("t4_timeout_ack", ack_data, 1);
                chk("t4_timeout_err", err, 1);
                chk("t4_timeout_rdata", rdata, 0);
                stb_data = 1'b0;
            end
        end
        step();
        #1;
        chk("t4_stb_dropped", mem_stb, 0);
        chk("t4_err_cleared", err, 0);
        stb_data = 1'b1;
        daddr    = 32'h0000_5004;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("t4_next_addr", mem_addr, 32'h5004);
        chk("t4_next_ack", ack_data, 1);
        chk("t4_next_rdata", rdata, 32'hCAFE_F00D);
        chk("t4_next_err", err, 0);
        stb_data = 1'b0;
        step();
        mem_ack = 1'b0;

        // 6. Ack arrives in the final watchdog cycle
        stb_inst = 1'b1;
        iaddr    = 32'h0000_0600;
        step();
        stb_inst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("t6_wait", ack_inst, 0);
            step();
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0050_0093;
        #1;
        chk("t6_ack_inst", ack_inst, 1);
        chk("t6_err", err, 0);
        chk("t6_inst", inst, 32'h0050_0093);
        step();
        mem_ack = 1'b0;
        #1;
        chk("t6_idle", mem_stb, 0);

        // 5. Reset pulse in the middle of a fetch
        stb_inst = 1'b1;
        iaddr    = 32'h0000_0700;
        step();
        #1;
        chk("t5_inst_busy", mem_stb, 1);
        step();
        rst_n = 1'b0;
        step();
        #1;
        chk("t5_rst_stb", mem_stb, 0);
        chk("t5_rst_ack_inst", ack_inst, 0);
        chk("t5_rst_ack_data", ack_data, 0);
        chk("t5_rst_addr", mem_addr, 0);
        rst_n = 1'b1;
        step();
        #1;
        chk("t5_regrant_stb", mem_stb, 1);
        chk("t5_regrant_addr", mem_addr, 32'h700);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0073;
        #1;
        chk("t5_regrant_ack", ack_inst, 1);
        chk("t5_regrant_inst", inst, 32'h73);
        stb_inst = 1'b0;
        step();
        mem_ack = 1'b0;
        #1;
        chk("t5_final_idle", mem_stb, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
